navegacao: RTL and testbench

Left-hand wall-following navigation controller for the maze robot. It samples the front and left wall sensors, tracks the robot's heading, and issues one-cycle rotate or advance commands. Its `orientacao` and `avancar` outputs drive the advance stage directly, so it sits immediately upstream of that stage. Heading encoding matches the advance stage: 001 N, 010 O (west), 011 L (east), 100 S.

---
 rtl/nav_pkg.sv | 41 ++++
 rtl/navegacao_contador_giros.sv | 28 ++
 rtl/navegacao.sv | 93 +++++++++
 tb/tb_navegacao.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// Shared definitions for the maze navigation path: heading codes, FSM states
// and the rotation helpers used by navegacao, the advance stage and benches.
package nav_pkg;

  localparam logic [2:0] RUMO_N = 3'b001;
  localparam logic [2:0] RUMO_O = 3'b010;
  localparam logic [2:0] RUMO_L = 3'b011;
  localparam logic [2:0] RUMO_S = 3'b100;

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    DECIDIR  = 3'd1,
    GIRA_ESQ = 3'd2,
    GIRA_DIR = 3'd3,
    AVANCA   = 3'd4,
    PRESO    = 3'd5
  } estado_t;

  // Counter-clockwise quarter turn; any illegal code recovers to north.
  function automatic logic [2:0] rot_esq(input logic [2:0] rumo);
    case (rumo)
      RUMO_N:  rot_esq = RUMO_O;
      RUMO_O:  rot_esq = RUMO_S;
      RUMO_S:  rot_esq = RUMO_L;
      RUMO_L:  rot_esq = RUMO_N;
      default: rot_esq = RUMO_N;
    endcase
  endfunction

  // Clockwise quarter turn; any illegal code recovers to north.
  function automatic logic [2:0] rot_dir(input logic [2:0] rumo);
    case (rumo)
      RUMO_N:  rot_dir = RUMO_L;
      RUMO_L:  rot_dir = RUMO_S;
      RUMO_S:  rot_dir = RUMO_O;
      RUMO_O:  rot_dir = RUMO_N;
      default: rot_dir = RUMO_N;
    endcase
  endfunction

endpackage

// File: rtl/navegacao_contador_giros.sv
// Trap counter: counts right turns since the last advance and flags when the
// count sits at TRAP_TURNS. Only instantiated when NAV_TRAP_DETECT_EN is defined.
module contador_giros #(
  parameter int TRAP_TURNS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic terminal
);

  logic [2:0] count;

  // Clear wins over increment so an advance always restarts the run of turns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 3'd0;
    end else if (clr) begin
      count <= 3'd0;
    end else if (inc) begin
      count <= count + 3'd1;
    end
  end

  assign terminal = (count == 3'(TRAP_TURNS));

endmodule

// File: rtl/navegacao.sv
// Left-hand wall-following navigation FSM for the maze robot.
// Optional trap detection is built when NAV_TRAP_DETECT_EN is defined.
module navegacao
  import nav_pkg::*;
#(
  parameter int TRAP_TURNS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       head,
  input  logic       left,
  output logic [2:0] orientacao,
  output logic       avancar,
  output logic       girar,
  output logic       preso
);

  if (TRAP_TURNS < 2 || TRAP_TURNS > 7) begin : g_param_check
    $error("navegacao: TRAP_TURNS must be in 2..7");
  end

  estado_t state;
  logic    virou_esq;
  logic    querEsq;
  logic    entraDir;
  logic    entraAvanca;
  logic    presoHit;

  // Decisions taken in DECIDIR, shared by the FSM and the trap counter.
  assign querEsq     = !left && !virou_esq;
  assign entraDir    = (state == DECIDIR) && enable && !querEsq && head;
  assign entraAvanca = (state == DECIDIR) && enable && !querEsq && !head;

`ifdef NAV_TRAP_DETECT_EN
  contador_giros #(
    .TRAP_TURNS (TRAP_TURNS)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .inc      (entraDir),
    .clr      (entraAvanca),
    .terminal (presoHit)
  );
`else
  assign presoHit = 1'b0;
`endif

  // Action states last one cycle and ignore enable; only DECIDIR can park.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PARADO;
      orientacao <= RUMO_N;
      virou_esq  <= 1'b0;
    end else begin
      case (state)
        PARADO: begin
          if (enable) state <= DECIDIR;
        end
        DECIDIR: begin
          if (!enable) begin
            state <= PARADO;
          end else if (querEsq) begin
            state      <= GIRA_ESQ;
            orientacao <= rot_esq(orientacao);
            virou_esq  <= 1'b1;
          end else if (!head) begin
            state     <= AVANCA;
            virou_esq <= 1'b0;
          end else begin
            state      <= GIRA_DIR;
            orientacao <= rot_dir(orientacao);
          end
        end
        GIRA_ESQ: state <= DECIDIR;
        AVANCA:   state <= DECIDIR;
        GIRA_DIR: state <= presoHit ? PRESO : DECIDIR;
        PRESO:    state <= PRESO;
        default:  state <= PARADO;
      endcase
    end
  end

  assign avancar = (state == AVANCA);
  assign girar   = (state == GIRA_ESQ) || (state == GIRA_DIR);

`ifdef NAV_TRAP_DETECT_EN
  assign preso = (state == PRESO);
`else
  assign preso = 1'b0;
`endif

endmodule

// File: tb/tb_navegacao.sv
// Self-checking bench for navegacao: directed corridor/trap runs plus random
// sensor sequences against a compass-index reference model.
module tb_navegacao;

  localparam int TRAP = 4;
`ifdef NAV_TRAP_DETECT_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  localparam int PH_IDLE    = 0;
  localparam int PH_DECIDE  = 1;
  localparam int PH_LEFT    = 2;
  localparam int PH_RIGHT   = 3;
  localparam int PH_ADVANCE = 4;
  localparam int PH_TRAPPED = 5;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       head;
  logic       left;
  logic [2:0] orientacao;
  logic       avancar;
  logic       girar;
  logic       preso;

  int testsRun    = 0;
  int testsFailed = 0;

  // Compass in counter-clockwise order: N, O(west), S, L(east).
  logic [2:0] compass [4];
  int mPhase;
  int mIdx;
  bit mBlocked;
  int mTurns;

  navegacao #(.TRAP_TURNS(TRAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .head       (head),
    .left       (left),
    .orientacao (orientacao),
    .avancar    (avancar),
    .girar      (girar),
    .preso      (preso)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase   = PH_IDLE;
    mIdx     = 0;
    mBlocked = 1'b0;
    mTurns   = 0;
  endtask

  // One robot step of the wall-following rules, at the behavioural level.
  task automatic modelClock(input bit en, input bit hd, input bit lf);
    case (mPhase)
      PH_IDLE: if (en) mPhase = PH_DECIDE;
      PH_DECIDE: begin
        if (!en) mPhase = PH_IDLE;
        else if (!lf && !mBlocked) begin
          mPhase = PH_LEFT; mIdx = (mIdx + 1) % 4; mBlocked = 1'b1;
        end else if (!hd) begin
          mPhase = PH_ADVANCE; mBlocked = 1'b0; mTurns = 0;
        end else begin
          mPhase = PH_RIGHT; mIdx = (mIdx + 3) % 4; mTurns++;
        end
      end
      PH_RIGHT: mPhase = (TRAP_ON && mTurns == TRAP) ? PH_TRAPPED : PH_DECIDE;
      PH_TRAPPED: mPhase = PH_TRAPPED;
      default: mPhase = PH_DECIDE;
    endcase
  endtask

  task automatic checkAll();
    checkOutput("orientacao", 32'(orientacao), 32'(compass[mIdx]));
    checkOutput("avancar", 32'(avancar), 32'(mPhase == PH_ADVANCE));
    checkOutput("girar", 32'(girar), 32'(mPhase == PH_LEFT || mPhase == PH_RIGHT));
    checkOutput("preso", 32'(preso), 32'(mPhase == PH_TRAPPED));
  endtask

  task automatic applyStimulus(input bit en, input bit hd, input bit lf);
    enable = en; head = hd; left = lf;
    @(posedge clock);
    modelClock(en, hd, lf);
    #1;
    checkAll();
  endtask

  // Asynchronous reset between edges: outputs must clear before the next edge.
  task automatic pulseReset();
    #3 reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clock);
    #1 reset = 1'b0;
    checkAll();
  endtask

  initial begin
    compass[0] = 3'b001;
    compass[1] = 3'b010;
    compass[2] = 3'b100;
    compass[3] = 3'b011;
    modelReset();
    reset = 1'b1; enable = 1'b0; head = 1'b0; left = 1'b0;
    #2;
    checkAll();
    @(posedge clock);
    #1 reset = 1'b0;

    // Straight corridor.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    pulseReset();

    // Open left held: turns and advances must alternate.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    pulseReset();

    // Dead corner held long enough to trap (or keep spinning without the macro).
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    pulseReset();

    // Enable dropped during a right turn.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    pulseReset();

    // Random sensor sequences with occasional mid-run resets.
    for (int seg = 0; seg < 20; seg++) begin
      for (int c = 0; c < 30; c++) begin
        applyStimulus(($urandom % 8) != 0, 1'($urandom % 2), 1'($urandom % 2));
        if (c == 15 && (seg % 3) == 0) pulseReset();
      end
      pulseReset();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
